debug_unit: RTL and testbench

// - Host-side controller for the MIPS pipeline's i_valid input.
// - Takes command bytes from the UART receiver.
// - Gates pipeline execution: continuous run or single step.
// - Counts executed cycles.
// - Serializes a state dump (PC, cycle count, 32 GPRs) to the UART transmitter.

---
 rtl/debug_unit_pkg.sv | 22 ++
 rtl/debug_word_serializer.sv | 57 +++++
 rtl/debug_unit.sv | 134 +++++++++++++
 tb/tb_debug_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_unit_pkg.sv
// Shared definitions for the debug unit: host command codes, FSM states and frame geometry.
package debug_unit_pkg;

  localparam logic [7:0] CMD_RUN  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] CMD_READ = 8'h52;  // 'R'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_SNAP,
    ST_RDWAIT,
    ST_SEND
  } state_t;

  // A frame carries PC, cycle counter, then every register of the file.
  function automatic int frame_words(input int regfile_depth);
    return 2 + regfile_depth;
  endfunction

endpackage

// File: rtl/debug_word_serializer.sv
// Splits one word into bytes, MSB first, over a valid/ready link; pulses o_done on the last accept.
module debug_word_serializer #(
  parameter int NB_WORD = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_WORD-1:0] i_word,
  input  logic               i_tx_ready,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_done
);

  localparam int NB_BYTES = NB_WORD / NB_BYTE;
  localparam int NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  logic [NB_WORD-1:0] r_shift;
  logic [NB_CNT-1:0]  r_left;
  logic               r_valid;
  logic               r_done;
  logic               w_accept;

  assign w_accept = r_valid & i_tx_ready;

  // NOTE: sequential state uses <= so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_shift <= '0;
      r_left  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_load) begin
        r_shift <= i_word;
        r_left  <= NB_CNT'(NB_BYTES - 1);
        r_valid <= 1'b1;
      end else if (w_accept) begin
        if (r_left == '0) begin
          r_valid <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_shift <= r_shift << NB_BYTE;
          r_left  <= r_left - 1'b1;
        end
      end
    end
  end

  // Byte only moves on an accepted transfer, so data holds steady under backpressure.
  assign o_tx_data  = r_shift[NB_WORD-1 -: NB_BYTE];
  assign o_tx_valid = r_valid;
  assign o_done     = r_done;

endmodule

// File: rtl/debug_unit.sv
// Host-side debug controller: gates the pipeline (run/step), counts executed cycles and dumps state over UART.
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int NB_REG        = 32,
  parameter int NB_BYTE       = 8,
  parameter int NB_REG_ADDR   = 5,
  parameter int REGFILE_DEPTH = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [NB_BYTE-1:0]     i_rx_data,
  input  logic                   i_rx_valid,
  output logic [NB_BYTE-1:0]     o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic                   o_pipe_valid,
  input  logic                   i_halt,
  input  logic [NB_REG-1:0]      i_pc,
  output logic [NB_REG_ADDR-1:0] o_reg_addr,
  input  logic [NB_REG-1:0]      i_reg_data,
  output logic                   o_busy
);

  localparam int FRAME_WORDS = frame_words(REGFILE_DEPTH);
  localparam int NB_WIDX     = $clog2(FRAME_WORDS);
  localparam logic [NB_WIDX-1:0] LAST_WORD = NB_WIDX'(FRAME_WORDS - 1);

  state_t                 r_state;
  logic [NB_REG-1:0]      r_cycle_cnt;
  logic [NB_REG-1:0]      r_cnt_word;
  logic [NB_REG-1:0]      r_ser_word;
  logic                   r_ser_load;
  logic                   r_pipe_valid;
  logic [NB_REG_ADDR-1:0] r_reg_addr;
  logic [NB_WIDX-1:0]     r_word;
  logic                   w_ser_done;

  debug_word_serializer #(
    .NB_WORD (NB_REG),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (r_ser_load),
    .i_word     (r_ser_word),
    .i_tx_ready (i_tx_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .o_done     (w_ser_done)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_cycle_cnt  <= '0;
      r_cnt_word   <= '0;
      r_ser_word   <= '0;
      r_ser_load   <= 1'b0;
      r_pipe_valid <= 1'b0;
      r_reg_addr   <= '0;
      r_word       <= '0;
    end else begin
      r_ser_load <= 1'b0;
      if (r_pipe_valid) r_cycle_cnt <= r_cycle_cnt + 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_RUN:  r_state <= ST_RUN;
              CMD_STEP: r_state <= ST_STEP;
              CMD_READ: r_state <= ST_SNAP;
              default:  r_state <= ST_IDLE;
            endcase
          end
        end
        ST_RUN: begin
          if (i_halt) begin
            r_pipe_valid <= 1'b0;
            r_state      <= ST_SNAP;
          end else begin
            r_pipe_valid <= 1'b1;
          end
        end
        ST_STEP: begin
          // Second STEP cycle closes the single-cycle pulse; a halted pipe gets no pulse.
          if (r_pipe_valid || i_halt) begin
            r_pipe_valid <= 1'b0;
            r_state      <= ST_SNAP;
          end else begin
            r_pipe_valid <= 1'b1;
          end
        end
        ST_SNAP: begin
          r_ser_word <= i_pc;
          r_cnt_word <= r_cycle_cnt;
          r_ser_load <= 1'b1;
          r_reg_addr <= '0;
          r_word     <= '0;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          if (w_ser_done) begin
            if (r_word == LAST_WORD) begin
              r_reg_addr <= '0;
              r_state    <= ST_IDLE;
            end else if (r_word == '0) begin
              r_ser_word <= r_cnt_word;
              r_ser_load <= 1'b1;
              r_word     <= r_word + 1'b1;
            end else begin
              r_state <= ST_RDWAIT;
            end
          end
        end
        ST_RDWAIT: begin
          // o_reg_addr has been stable for at least a cycle, so i_reg_data is valid here.
          r_ser_word <= i_reg_data;
          r_ser_load <= 1'b1;
          r_reg_addr <= r_reg_addr + 1'b1;
          r_word     <= r_word + 1'b1;
          r_state    <= ST_SEND;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_pipe_valid = r_pipe_valid;
  assign o_reg_addr   = r_reg_addr;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: expected frames are queued at command time, a monitor checks accepted bytes.
module tb_debug_unit;
  import debug_unit_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_pipe_valid;
  logic        i_halt;
  logic [31:0] i_pc;
  logic [4:0]  o_reg_addr;
  logic [31:0] i_reg_data;
  logic        o_busy;

  debug_unit dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .o_pipe_valid (o_pipe_valid),
    .i_halt       (i_halt),
    .i_pc         (i_pc),
    .o_reg_addr   (o_reg_addr),
    .i_reg_data   (i_reg_data),
    .o_busy       (o_busy)
  );

  always #5 i_clock = ~i_clock;

  // Register file model: synchronous debug read port, one cycle latency.
  logic [31:0] model_regs [32];
  always @(posedge i_clock) i_reg_data <= model_regs[o_reg_addr];

  int          n_checks   = 0;
  int          n_errors   = 0;
  int          acc_bytes  = 0;
  int          pv_cycles  = 0;
  int          ready_mode = 0;
  logic [31:0] model_cnt  = 0;
  logic [7:0]  exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame is PC, counter, r0..r31, each word MSB first.
  task automatic push_frame(input logic [31:0] pc, input logic [31:0] cnt);
    logic [31:0] w;
    for (int k = 0; k < 34; k++) begin
      w = (k == 0) ? pc : (k == 1) ? cnt : model_regs[k-2];
      for (int b = 3; b >= 0; b--) exp_q.push_back(8'(w >> (8 * b)));
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(posedge i_clock); #1;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge i_clock); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int k;
    for (k = 0; k < 5000; k++) begin
      @(negedge i_clock);
      if (exp_q.size() == 0 && !o_busy) break;
    end
    if (k == 5000) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: %0d bytes still expected, busy=%0b", name, exp_q.size(), o_busy);
    end
    check({name, "_reg_addr"}, 32'(o_reg_addr), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tx_data"},    32'(o_tx_data), 0);
    check({name, "_tx_valid"},   32'(o_tx_valid), 0);
    check({name, "_pipe_valid"}, 32'(o_pipe_valid), 0);
    check({name, "_reg_addr"},   32'(o_reg_addr), 0);
    check({name, "_busy"},       32'(o_busy), 0);
  endtask

  task automatic randomize_state();
    for (int k = 0; k < 32; k++) model_regs[k] = $urandom;
    i_pc = $urandom;
  endtask

  // Ready pattern: 0 = always, 1 = one cycle in three, 2 = random.
  initial begin : ready_drv
    int ph;
    ph = 0;
    forever begin
      @(posedge i_clock); #1;
      case (ready_mode)
        0:       i_tx_ready = 1'b1;
        1:       i_tx_ready = (ph == 0);
        default: i_tx_ready = 1'($urandom_range(0, 1));
      endcase
      ph = (ph == 2) ? 0 : ph + 1;
    end
  end

  // Monitor: a byte transfers at the posedge following a negedge that sees valid & ready.
  initial begin : monitor
    logic       stall;
    logic [7:0] stall_data;
    logic [7:0] e;
    stall = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge i_clock);
      if (!i_reset) begin
        stall = 1'b0;
        continue;
      end
      if (o_pipe_valid) pv_cycles++;
      if (stall) begin
        check("tx_hold_valid", 32'(o_tx_valid), 1);
        check("tx_hold_data", 32'(o_tx_data), 32'(stall_data));
      end
      if (o_tx_valid && i_tx_ready) begin
        acc_bytes++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_byte: got 0x%0h with no byte expected", o_tx_data);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("byte%0d", acc_bytes - 1), 32'(o_tx_data), 32'(e));
        end
      end
      stall      = o_tx_valid && !i_tx_ready;
      stall_data = o_tx_data;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int k;
    i_rx_data  = '0;
    i_rx_valid = 1'b0;
    i_tx_ready = 1'b1;
    i_halt     = 1'b0;
    i_pc       = 32'h0000_0040;
    for (int r = 0; r < 32; r++) model_regs[r] = 32'h100 + r;

    #2 i_reset = 1'b0;
    repeat (3) @(posedge i_clock);
    #1 check_reset_outputs("reset");
    i_reset = 1'b1;

    // Dump after reset.
    push_frame(i_pc, model_cnt);
    acc_bytes = 0; pv_cycles = 0;
    send_cmd(CMD_READ);
    wait_frame("dump");
    check("dump_bytes", acc_bytes, 136);
    check("dump_pv", pv_cycles, 0);
    check("dump_busy_after", 32'(o_busy), 0);

    // Same dump under 1-in-3 backpressure.
    ready_mode = 1;
    push_frame(i_pc, model_cnt);
    acc_bytes = 0;
    send_cmd(CMD_READ);
    wait_frame("bp");
    check("bp_bytes", acc_bytes, 136);

    // Stepping with random PC/regfile and random ready.
    ready_mode = 2;
    for (int s = 0; s < 3; s++) begin
      randomize_state();
      model_cnt = model_cnt + 1;
      push_frame(i_pc, model_cnt);
      pv_cycles = 0;
      send_cmd(CMD_STEP);
      wait_frame($sformatf("step%0d", s));
      check($sformatf("step%0d_pv", s), pv_cycles, 1);
    end
    i_halt = 1'b1;
    push_frame(i_pc, model_cnt);
    pv_cycles = 0;
    send_cmd(CMD_STEP);
    wait_frame("step_halted");
    check("step_halted_pv", pv_cycles, 0);
    i_halt = 1'b0;

    // Run to halt after 10 advance cycles, from a fresh counter.
    i_reset = 1'b0;
    @(negedge i_clock);
    i_reset = 1'b1;
    model_cnt = 0;
    ready_mode = 0;
    randomize_state();
    model_cnt = model_cnt + 10;
    push_frame(i_pc, model_cnt);
    pv_cycles = 0;
    send_cmd(CMD_RUN);
    for (k = 0; k < 500; k++) begin
      @(negedge i_clock); #1;
      if (pv_cycles == 10) begin
        i_halt = 1'b1;
        break;
      end
    end
    if (k == 500) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_start: only %0d advance cycles seen, need 10", pv_cycles);
      i_halt = 1'b1;
    end
    wait_frame("run");
    check("run_pv", pv_cycles, 10);
    push_frame(i_pc, model_cnt);
    pv_cycles = 0;
    send_cmd(CMD_RUN);
    wait_frame("run_halted");
    check("run_halted_pv", pv_cycles, 0);
    i_halt = 1'b0;

    // Ignored bytes in IDLE, dropped commands during a dump.
    ready_mode = 2;
    pv_cycles = 0; acc_bytes = 0;
    send_cmd(8'h00);
    send_cmd(8'hFF);
    repeat (5) @(negedge i_clock);
    check("ignored_busy", 32'(o_busy), 0);
    push_frame(i_pc, model_cnt);
    send_cmd(CMD_READ);
    repeat (20) @(posedge i_clock);
    send_cmd(CMD_READ);
    send_cmd(CMD_STEP);
    wait_frame("drop");
    repeat (300) @(negedge i_clock);
    check("drop_bytes", acc_bytes, 136);
    check("drop_pv", pv_cycles, 0);
    check("drop_busy", 32'(o_busy), 0);

    // Reset in the middle of a frame.
    ready_mode = 0;
    push_frame(i_pc, model_cnt);
    acc_bytes = 0;
    send_cmd(CMD_READ);
    for (k = 0; k < 2000; k++) begin
      @(negedge i_clock); #1;
      if (acc_bytes == 50) break;
    end
    if (k == 2000) begin
      n_checks++;
      n_errors++;
      $display("FAIL midreset_wait: %0d bytes accepted, need 50", acc_bytes);
    end
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    #1 check_reset_outputs("midreset");
    exp_q.delete();
    model_cnt = 0;
    @(negedge i_clock);
    i_reset = 1'b1;
    push_frame(i_pc, model_cnt);
    acc_bytes = 0;
    send_cmd(CMD_READ);
    wait_frame("after_reset");
    check("after_reset_bytes", acc_bytes, 136);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
